// File: rtl/fetch_stall_responder_pkg.sv
// Shared pipeline definitions for the fetch stage.
// Holds reset/bubble constants, fetch-state encodings and the word-alignment helper.
package fetch_stall_responder_pkg;

   localparam logic [31:0] RESET_PC_DEF      = 32'h0000_3000;
   localparam logic [31:0] NOP_INSTR_DEF     = 32'h0000_0000;
   localparam int          STALL_TIMEOUT_DEF = 8;
   localparam int          CNT_W_DEF         = 16;

   typedef enum logic [1:0] {
      FS_RUN     = 2'd0,
      FS_STALL   = 2'd1,
      FS_FLUSH   = 2'd2,
      FS_ILLEGAL = 2'd3
   } fetch_state_e;

   // Instruction fetches are word aligned, so the low two address bits are dropped.
   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_stall_responder_sat_counter.sv
// Saturating event counter: increments on inc_i and sticks at all-ones.
module fetch_stall_responder_sat_counter
   import fetch_stall_responder_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   output logic [CNT_W-1:0] count_o
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc_i && (count_q != {CNT_W{1'b1}})) begin
         count_d = count_q + CNT_W'(1);
      end else begin
         count_d = count_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= {CNT_W{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/fetch_stall_responder.sv
// Fetch-stage owner of the PC and IF/ID register; turns stall and redirect
// requests into held PCs, NOP bubbles and target loads.
module fetch_stall_responder
   import fetch_stall_responder_pkg::*;
#(
   parameter logic [31:0] RESET_PC      = RESET_PC_DEF,
   parameter logic [31:0] NOP_INSTR     = NOP_INSTR_DEF,
   parameter int          STALL_TIMEOUT = STALL_TIMEOUT_DEF,
   parameter int          CNT_W         = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall_in_i,
   input  logic             redirect_valid_i,
   input  logic [31:0]      redirect_pc_i,
   output logic [31:0]      imem_addr_o,
   input  logic [31:0]      imem_rdata_i,
   output logic [31:0]      ifid_instr_o,
   output logic [31:0]      ifid_pc4_o,
   output logic             ifid_valid_o,
   output logic [1:0]       fetch_state_o,
   output logic             stall_timeout_o,
   output logic [CNT_W-1:0] bubble_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   localparam int             RUN_W     = $clog2(STALL_TIMEOUT + 1);
   localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(STALL_TIMEOUT);

   logic [31:0]      pc_q,         pc_d;
   logic [31:0]      ifid_instr_q, ifid_instr_d;
   logic [31:0]      ifid_pc4_q,   ifid_pc4_d;
   logic             ifid_valid_q, ifid_valid_d;
   fetch_state_e     state_q,      state_d;
   logic [RUN_W-1:0] run_q,        run_d;
   logic             timeout_q,    timeout_d;
   logic             bubble_inc_s;
   logic             flush_inc_s;

   // Redirect beats stall beats normal fetch; every branch sets the state,
   // so the unused encoding falls back into the table on the next edge.
   always_comb begin
      pc_d         = pc_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pc4_d   = ifid_pc4_q;
      ifid_valid_d = ifid_valid_q;
      state_d      = state_q;
      run_d        = run_q;
      bubble_inc_s = 1'b0;
      flush_inc_s  = 1'b0;
      if (redirect_valid_i) begin
         pc_d         = align_word(redirect_pc_i);
         ifid_instr_d = NOP_INSTR;
         ifid_pc4_d   = 32'h0000_0000;
         ifid_valid_d = 1'b0;
         state_d      = FS_FLUSH;
         flush_inc_s  = 1'b1;
         run_d        = {RUN_W{1'b0}};
      end else if (stall_in_i) begin
         ifid_instr_d = NOP_INSTR;
         ifid_pc4_d   = 32'h0000_0000;
         ifid_valid_d = 1'b0;
         state_d      = FS_STALL;
         bubble_inc_s = 1'b1;
         if (run_q != RUN_LIMIT) begin
            run_d = run_q + RUN_W'(1);
         end else begin
            run_d = run_q;
         end
      end else begin
         pc_d         = pc_q + 32'd4;
         ifid_instr_d = imem_rdata_i;
         ifid_pc4_d   = pc_q + 32'd4;
         ifid_valid_d = 1'b1;
         state_d      = FS_RUN;
         run_d        = {RUN_W{1'b0}};
      end
      timeout_d = timeout_q | (run_d == RUN_LIMIT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q         <= RESET_PC;
         ifid_instr_q <= NOP_INSTR;
         ifid_pc4_q   <= 32'h0000_0000;
         ifid_valid_q <= 1'b0;
         state_q      <= FS_RUN;
         run_q        <= {RUN_W{1'b0}};
         timeout_q    <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pc4_q   <= ifid_pc4_d;
         ifid_valid_q <= ifid_valid_d;
         state_q      <= state_d;
         run_q        <= run_d;
         timeout_q    <= timeout_d;
      end
   end

   fetch_stall_responder_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (bubble_inc_s),
      .count_o (bubble_cnt_o)
   );

   fetch_stall_responder_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (flush_inc_s),
      .count_o (flush_cnt_o)
   );

   assign imem_addr_o     = pc_q;
   assign ifid_instr_o    = ifid_instr_q;
   assign ifid_pc4_o      = ifid_pc4_q;
   assign ifid_valid_o    = ifid_valid_q;
   assign fetch_state_o   = state_q;
   assign stall_timeout_o = timeout_q;

endmodule
